// File: rtl/prog_mem_pkg.sv
// Shared widths, response FIFO sizing and the response payload type for the
// program memory fetch unit.
package prog_mem_pkg;

  localparam int PM_ADDR_W      = 8;
  localparam int PM_DATA_W      = 17;
  localparam logic [PM_DATA_W-1:0] PM_DEFAULT_WORD = 17'h2;

  localparam int RSP_FIFO_DEPTH = 3;
  localparam int FIFO_PTR_W     = 2;
  localparam int FIFO_CNT_W     = 2;

  typedef struct packed {
    logic [PM_DATA_W-1:0] data;
    logic [PM_ADDR_W-1:0] addr;
    logic                 err;
  } rsp_t;

  // Pointer increment that wraps at the non-power-of-two FIFO depth.
  function automatic logic [FIFO_PTR_W-1:0] fifo_ptr_inc(input logic [FIFO_PTR_W-1:0] ptr);
    return (ptr == FIFO_PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : ptr + FIFO_PTR_W'(1);
  endfunction

endpackage

// File: rtl/prog_mem_rsp_fifo.sv
// Three-entry synchronous response FIFO; the head is only visible once an
// entry has been written, so there is no fall-through path.
module prog_mem_rsp_fifo
  import prog_mem_pkg::*;
#(
  parameter type T = rsp_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  T                      push_data,
  input  logic                  pop,
  output T                      head,
  output logic [FIFO_CNT_W-1:0] count
);

  T                      entries_q [RSP_FIFO_DEPTH];
  T                      entries_d [RSP_FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop    = pop && (count_q != '0);
    do_push   = push && ((count_q != FIFO_CNT_W'(RSP_FIFO_DEPTH)) || do_pop);
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (do_push) begin
      entries_d[wr_ptr_q] = push_data;
      wr_ptr_d            = fifo_ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = fifo_ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + FIFO_CNT_W'(1);
      2'b01:   count_d = count_q - FIFO_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign head  = entries_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/prog_mem_fetch.sv
// Synchronous program memory with a valid/ready fetch port feeding the decoder
// and a run-time program-load port; responses return in request order.
module prog_mem_fetch
  import prog_mem_pkg::*;
#(
  parameter int                ADDR_W       = PM_ADDR_W,
  parameter int                DATA_W       = PM_DATA_W,
  parameter int                DEPTH        = 256,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(PM_DEFAULT_WORD),
  parameter string             INIT_FILE    = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_EXT = 32'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } rsp_word_t;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     rd_data_q;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_err_q, s1_err_d;
  logic [ADDR_W-1:0]     s1_addr_q, s1_addr_d;
  logic                  ld_err_q, ld_err_d;
  logic                  req_fire, req_in_range, ld_in_range;
  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  rsp_word_t             fifo_head, s1_word, rsp_word;

  assign req_in_range = 32'(req_addr) < DEPTH_EXT;
  assign ld_in_range  = 32'(ld_addr) < DEPTH_EXT;

  // Only registered occupancy feeds req_ready, so rsp_ready never reaches it.
  assign req_ready = !rst && !ld_en
                     && ((32'(fifo_count) + 32'(s1_valid_q)) < 32'(RSP_FIFO_DEPTH));
  assign req_fire  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      mem_q[ld_addr[IDX_W-1:0]] <= ld_data;
    end
    if (req_fire && req_in_range) begin
      rd_data_q <= mem_q[req_addr[IDX_W-1:0]];
    end
  end

  always_comb begin
    s1_valid_d = req_fire;
    s1_addr_d  = s1_addr_q;
    s1_err_d   = s1_err_q;
    if (req_fire) begin
      s1_addr_d = req_addr;
      s1_err_d  = !req_in_range;
    end
    ld_err_d = ld_en && !ld_in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_err_q   <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_err_q   <= s1_err_d;
      ld_err_q   <= ld_err_d;
    end
  end

  // s1 bypasses an empty FIFO and only enters it when it cannot leave directly.
  always_comb begin
    s1_word.data = s1_err_q ? DEFAULT_WORD : rd_data_q;
    s1_word.addr = s1_addr_q;
    s1_word.err  = s1_err_q;
    fifo_empty   = (fifo_count == '0);
    rsp_word     = fifo_empty ? s1_word : fifo_head;
    fifo_pop     = rsp_ready && !fifo_empty;
    fifo_push    = s1_valid_q && !(fifo_empty && rsp_ready);
  end

  prog_mem_rsp_fifo #(
    .T(rsp_word_t)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(s1_word),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign rsp_valid = !fifo_empty || s1_valid_q;
  assign rsp_data  = rsp_valid ? rsp_word.data : '0;
  assign rsp_addr  = rsp_valid ? rsp_word.addr : '0;
  assign rsp_err   = rsp_valid && rsp_word.err;
  assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_prog_mem_fetch.sv
// Bench for prog_mem_fetch: a 256-word instance for streaming, backpressure,
// load and reset sequences, and a 16-word instance for range errors and random traffic.
`timescale 1ns/1ps
module tb_prog_mem_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic        ld_en = 1'b0, ld_err;
  logic [7:0]  req_addr = '0, rsp_addr, ld_addr = '0;
  logic [16:0] rsp_data, ld_data = '0;

  logic        s_req_valid = 1'b0, s_req_ready, s_rsp_valid, s_rsp_ready = 1'b0, s_rsp_err;
  logic        s_ld_en = 1'b0, s_ld_err;
  logic [7:0]  s_req_addr = '0, s_rsp_addr, s_ld_addr = '0;
  logic [16:0] s_rsp_data, s_ld_data = '0;

  int checks = 0;
  int errors = 0;

  prog_mem_fetch dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err)
  );

  prog_mem_fetch #(.DEPTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_addr(s_req_addr),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
    .rsp_addr(s_rsp_addr), .rsp_err(s_rsp_err),
    .ld_en(s_ld_en), .ld_addr(s_ld_addr), .ld_data(s_ld_data), .ld_err(s_ld_err)
  );

  typedef struct {
    logic        rv;
    logic [7:0]  ra;
    logic        rr;
    logic        le;
    logic [7:0]  la;
    logic [16:0] ld;
    logic        exp_ready;
    logic        exp_valid;
    logic [16:0] exp_data;
    logic [7:0]  exp_addr;
  } vec_t;

  typedef struct {
    logic [16:0] data;
    logic [7:0]  addr;
    logic        err;
  } exp_t;

  vec_t        vecs [24];
  exp_t        exp_q [$];
  logic [16:0] model16 [16];

  function automatic vec_t mk(input logic rv, input logic [7:0] ra, input logic rr,
                              input logic le, input logic [7:0] la, input logic [16:0] ld,
                              input logic er, input logic ev, input logic [16:0] ed,
                              input logic [7:0] ea);
    vec_t v;
    v.rv = rv; v.ra = ra; v.rr = rr; v.le = le; v.la = la; v.ld = ld;
    v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed; v.exp_addr = ea;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle on the 256-word instance; outputs are sampled at the following negedge.
  task automatic applyStimulus(input logic r, input logic rv, input logic [7:0] ra,
                               input logic rr, input logic le, input logic [7:0] la,
                               input logic [16:0] ld);
    @(posedge clk);
    #1;
    rst = r; req_valid = rv; req_addr = ra; rsp_ready = rr;
    ld_en = le; ld_addr = la; ld_data = ld;
    @(negedge clk);
  endtask

  task automatic apply16(input logic r, input logic rv, input logic [7:0] ra,
                         input logic rr, input logic le, input logic [7:0] la,
                         input logic [16:0] ld);
    @(posedge clk);
    #1;
    rst = r; s_req_valid = rv; s_req_addr = ra; s_rsp_ready = rr;
    s_ld_en = le; s_ld_addr = la; s_ld_data = ld;
    @(negedge clk);
  endtask

  task automatic check16(input string name, input logic ev, input logic [16:0] ed,
                         input logic [7:0] ea, input logic ee);
    checkOutput({name, "_valid"}, 32'(s_rsp_valid), 32'(ev));
    if (ev) begin
      checkOutput({name, "_data"}, 32'(s_rsp_data), 32'(ed));
      checkOutput({name, "_addr"}, 32'(s_rsp_addr), 32'(ea));
      checkOutput({name, "_err"}, 32'(s_rsp_err), 32'(ee));
    end
  endtask

  initial begin
    logic        r, rv, rr, le, exp_ready, prev_bad;
    logic [7:0]  ra, la;
    logic [16:0] ld;
    exp_t        e;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'(0));
    checkOutput("rst_rsp_addr", 32'(rsp_addr), 32'(0));
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'(0));
    checkOutput("rst_ld_err", 32'(ld_err), 32'(0));
    checkOutput("rst_req_ready", 32'(req_ready), 32'(0));
    checkOutput("rst16_rsp_valid", 32'(s_rsp_valid), 32'(0));

    // Program word[i] = i through the load port
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 1, 8'(i), 1, 1, 8'(i), 17'(i));
      if (i == 0 || i == 255) checkOutput("load_req_ready", 32'(req_ready), 32'(0));
    end

    // Stream 0x00..0x17 with rsp_ready held high
    for (int k = 0; k < 25; k++) begin
      applyStimulus(0, k < 24, 8'(k), 1, 0, 0, 0);
      checkOutput("t1_req_ready", 32'(req_ready), 32'(1));
      checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'(k > 0));
      if (k > 0) begin
        checkOutput("t1_rsp_data", 32'(rsp_data), 32'(k - 1));
        checkOutput("t1_rsp_addr", 32'(rsp_addr), 32'(k - 1));
        checkOutput("t1_rsp_err", 32'(rsp_err), 32'(0));
      end
    end
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("t1_idle_valid", 32'(rsp_valid), 32'(0));

    // Backpressure, load priority, in-flight old data, back-to-back loads
    vecs[0]  = mk(1, 8'h05, 0, 0, 0, 0,         1, 0, 0,         0);
    vecs[1]  = mk(1, 8'h06, 0, 0, 0, 0,         1, 1, 17'h00005, 8'h05);
    vecs[2]  = mk(1, 8'h07, 0, 0, 0, 0,         1, 1, 17'h00005, 8'h05);
    vecs[3]  = mk(1, 8'h08, 0, 0, 0, 0,         0, 1, 17'h00005, 8'h05);
    vecs[4]  = mk(1, 8'h08, 0, 0, 0, 0,         0, 1, 17'h00005, 8'h05);
    vecs[5]  = mk(1, 8'h08, 0, 0, 0, 0,         0, 1, 17'h00005, 8'h05);
    vecs[6]  = mk(0, 8'h00, 1, 0, 0, 0,         0, 1, 17'h00005, 8'h05);
    vecs[7]  = mk(0, 8'h00, 1, 0, 0, 0,         1, 1, 17'h00006, 8'h06);
    vecs[8]  = mk(0, 8'h00, 1, 0, 0, 0,         1, 1, 17'h00007, 8'h07);
    vecs[9]  = mk(0, 8'h00, 1, 0, 0, 0,         1, 0, 0,         0);
    vecs[10] = mk(1, 8'h10, 1, 1, 8'h10, 17'h1ABCD, 0, 0, 0,     0);
    vecs[11] = mk(1, 8'h10, 1, 0, 0, 0,         1, 0, 0,         0);
    vecs[12] = mk(0, 8'h00, 1, 0, 0, 0,         1, 1, 17'h1ABCD, 8'h10);
    vecs[13] = mk(1, 8'h11, 0, 0, 0, 0,         1, 0, 0,         0);
    vecs[14] = mk(0, 8'h00, 0, 1, 8'h11, 17'h0F0F0, 0, 1, 17'h00011, 8'h11);
    vecs[15] = mk(1, 8'h11, 1, 0, 0, 0,         1, 1, 17'h00011, 8'h11);
    vecs[16] = mk(0, 8'h00, 1, 0, 0, 0,         1, 1, 17'h0F0F0, 8'h11);
    vecs[17] = mk(0, 8'h00, 1, 0, 0, 0,         1, 0, 0,         0);
    vecs[18] = mk(1, 8'h03, 1, 1, 8'h20, 17'h00123, 0, 0, 0,     0);
    vecs[19] = mk(1, 8'h03, 1, 1, 8'h21, 17'h00456, 0, 0, 0,     0);
    vecs[20] = mk(1, 8'h20, 1, 0, 0, 0,         1, 0, 0,         0);
    vecs[21] = mk(1, 8'h21, 1, 0, 0, 0,         1, 1, 17'h00123, 8'h20);
    vecs[22] = mk(0, 8'h00, 1, 0, 0, 0,         1, 1, 17'h00456, 8'h21);
    vecs[23] = mk(0, 8'h00, 1, 0, 0, 0,         1, 0, 0,         0);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(0, vecs[i].rv, vecs[i].ra, vecs[i].rr, vecs[i].le, vecs[i].la, vecs[i].ld);
      checkOutput($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_ld_err", i), 32'(ld_err), 32'(0));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].exp_data));
        checkOutput($sformatf("vec%0d_rsp_addr", i), 32'(rsp_addr), 32'(vecs[i].exp_addr));
        checkOutput($sformatf("vec%0d_rsp_err", i), 32'(rsp_err), 32'(0));
      end
    end

    // Reset with three responses queued
    applyStimulus(0, 1, 8'h10, 0, 0, 0, 0);
    applyStimulus(0, 1, 8'h11, 0, 0, 0, 0);
    applyStimulus(0, 1, 8'h12, 0, 0, 0, 0);
    checkOutput("t6_third_ready", 32'(req_ready), 32'(1));
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_pre_rst_valid", 32'(rsp_valid), 32'(1));
    checkOutput("t6_rst_ready", 32'(req_ready), 32'(0));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t6_post_rst_valid", 32'(rsp_valid), 32'(0));
    end
    applyStimulus(0, 1, 8'h21, 1, 0, 0, 0);
    checkOutput("t6_refetch_ready", 32'(req_ready), 32'(1));
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("t6_refetch_valid", 32'(rsp_valid), 32'(1));
    checkOutput("t6_refetch_data", 32'(rsp_data), 32'(17'h00456));
    checkOutput("t6_refetch_addr", 32'(rsp_addr), 32'(8'h21));
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("t6_end_valid", 32'(rsp_valid), 32'(0));

    // Range boundaries on the 16-word instance
    apply16(0, 0, 0, 1, 1, 8'h00, 17'h0AAAA);
    checkOutput("t4_ld_ready", 32'(s_req_ready), 32'(0));
    apply16(0, 0, 0, 1, 1, 8'h0F, 17'h1F00F);
    checkOutput("t4_ld_err_a", 32'(s_ld_err), 32'(0));
    apply16(0, 0, 0, 1, 1, 8'h20, 17'h15555);
    checkOutput("t4_ld_err_b", 32'(s_ld_err), 32'(0));
    apply16(0, 1, 8'h20, 1, 0, 0, 0);
    checkOutput("t4_ld_err_pulse", 32'(s_ld_err), 32'(1));
    checkOutput("t4_req_ready", 32'(s_req_ready), 32'(1));
    check16("t4_idle", 0, 0, 0, 0);
    apply16(0, 1, 8'h00, 1, 0, 0, 0);
    checkOutput("t4_ld_err_clear", 32'(s_ld_err), 32'(0));
    check16("t4_oor", 1, 17'h00002, 8'h20, 1);
    apply16(0, 1, 8'h0F, 1, 0, 0, 0);
    check16("t4_word0_kept", 1, 17'h0AAAA, 8'h00, 0);
    apply16(0, 1, 8'h10, 1, 0, 0, 0);
    check16("t4_last_in_range", 1, 17'h1F00F, 8'h0F, 0);
    apply16(0, 0, 0, 1, 0, 0, 0);
    check16("t4_first_oor", 1, 17'h00002, 8'h10, 1);
    apply16(0, 0, 0, 1, 0, 0, 0);
    check16("t4_drained", 0, 0, 0, 0);

    // Random traffic on the 16-word instance against a queue model
    for (int i = 0; i < 16; i++) begin
      ld = 17'($urandom);
      model16[i] = ld;
      apply16(0, 0, 0, 1, 1, 8'(i), ld);
    end
    exp_q.delete();
    prev_bad = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r  = ($urandom_range(0, 499) == 0);
      le = !r && ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 2) != 0);
      ra = 8'($urandom_range(0, 31));
      rr = ($urandom_range(0, 3) > 1);
      la = 8'($urandom_range(0, 31));
      ld = 17'($urandom);
      apply16(r, rv, ra, rr, le, la, ld);
      exp_ready = !r && !le && (exp_q.size() < 3);
      checkOutput("rnd_req_ready", 32'(s_req_ready), 32'(exp_ready));
      checkOutput("rnd_ld_err", 32'(s_ld_err), 32'(prev_bad));
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check16("rnd_rsp", 1, e.data, e.addr, e.err);
      end else begin
        check16("rnd_rsp", 0, 0, 0, 0);
      end
      if (r) begin
        exp_q.delete();
        prev_bad = 1'b0;
      end else begin
        if (exp_q.size() > 0 && rr) void'(exp_q.pop_front());
        if (rv && exp_ready) begin
          e.addr = ra;
          e.err  = (ra >= 8'd16);
          e.data = e.err ? 17'h00002 : model16[ra[3:0]];
          exp_q.push_back(e);
        end
        prev_bad = le && (la >= 8'd16);
        if (le && la < 8'd16) model16[la[3:0]] = ld;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
